// File: rtl/sa_pkg.sv
// Shared types for the systolic-array data feeder: default geometry, row type, FSM states.
package sa_pkg;

  localparam int unsigned SaWidth     = 8;
  localparam int unsigned SaDataWidth = 8;

  typedef logic [SaWidth-1:0][SaDataWidth-1:0] row_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFlush,
    StDone
  } feed_state_t;

endpackage

// File: rtl/sa_feed_fifo.sv
// Two-entry row FIFO. The feeder's read credit keeps at most two rows outstanding,
// so a push never arrives while the FIFO is full.
module sa_feed_fifo
  import sa_pkg::*;
#(
  parameter int unsigned RowBits = $bits(row_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [RowBits-1:0] wdata_i,
  input  logic               pop_i,
  output logic [RowBits-1:0] rdata_o,
  output logic [1:0]         count_o
);

  logic [RowBits-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sa_data_feeder.sv
// Streams a tile of activation rows from the buffer into the systolic array input,
// followed by a number of all-zero drain rows, honouring a downstream stall.
module sa_data_feeder
  import sa_pkg::*;
#(
  parameter int unsigned WIDTH      = SaWidth,
  parameter int unsigned DATA_WIDTH = SaDataWidth,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [CNT_W-1:0]                    num_rows,
  input  logic [3:0]                          flush_rows,
  input  logic                                sign_en,
  input  logic                                stall,
  output logic                                rd_en,
  output logic [ADDR_W-1:0]                   rd_addr,
  input  logic [WIDTH*DATA_WIDTH-1:0]         rd_data,
  output logic                                data_iv,
  output logic [WIDTH-1:0][DATA_WIDTH-1:0]    data_id,
  output logic                                data_sign_en,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned RowBits = WIDTH * DATA_WIDTH;

  feed_state_t state_q, state_d;

  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   left_q, left_d;          // reads still to issue after the current one
  logic [3:0]         flush_left_q, flush_left_d;
  logic               rvalid_q;                // rd_data carries a row this cycle
  logic               sign_q, sign_d;
  logic               data_iv_q, data_iv_d;
  logic [RowBits-1:0] data_id_q, data_id_d;

  logic               push, pop;
  logic [RowBits-1:0] fifo_rdata;
  logic [1:0]         fifo_cnt, fifo_cnt_nxt;
  logic               drained, flush_avail, credit_ok;

  sa_feed_fifo #(
    .RowBits (RowBits)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rd_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  // Every data row has been issued, returned and handed to the output register.
  assign drained = (state_q == StFetch) && (left_q == '0) && !rd_en_q && !rvalid_q &&
                   (fifo_cnt == 2'd0);
  // Flush beats start in the drained cycle so data and zero rows run back to back.
  assign flush_avail = ((state_q == StFlush) || drained) && (flush_left_q != 4'd0);

  assign fifo_cnt_nxt = fifo_cnt + 2'(push) - 2'(pop);
  // Rows buffered next cycle plus the read landing next cycle must leave room for one more.
  assign credit_ok = ({1'b0, fifo_cnt_nxt} + {2'b00, rd_en_q}) < 3'd2;

  // Output register source select: FIFO head first (ordering), then bypass, then flush.
  always_comb begin
    data_iv_d    = 1'b0;
    data_id_d    = data_id_q;
    push         = 1'b0;
    pop          = 1'b0;
    flush_left_d = flush_left_q;
    if ((state_q == StIdle) && start) begin
      flush_left_d = flush_rows;
    end else if ((state_q == StFetch) || (state_q == StFlush)) begin
      if (!stall) begin
        if (fifo_cnt != 2'd0) begin
          data_iv_d = 1'b1;
          data_id_d = fifo_rdata;
          pop       = 1'b1;
          push      = rvalid_q;
        end else if (rvalid_q) begin
          data_iv_d = 1'b1;
          data_id_d = rd_data;
        end else if (flush_avail) begin
          data_iv_d    = 1'b1;
          data_id_d    = '0;
          flush_left_d = flush_left_q - 4'd1;
        end
      end else begin
        push = rvalid_q;
      end
    end
  end

  // Tile sequencing and read issue.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    left_d    = left_q;
    sign_d    = sign_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d    = sign_en;
          rd_addr_d = base_addr;
          if (num_rows != '0) begin
            state_d = StFetch;
            rd_en_d = 1'b1;
            left_d  = num_rows - CNT_W'(1);
          end else if (flush_rows != 4'd0) begin
            state_d = StFlush;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if ((left_q != '0) && credit_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          left_d    = left_q - CNT_W'(1);
        end
        if (drained) begin
          state_d = (flush_left_q != 4'd0) ? StFlush : StDone;
        end
      end
      StFlush: begin
        if (flush_left_q == 4'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons the tile and drops any read still returning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      left_q       <= '0;
      flush_left_q <= 4'd0;
      rvalid_q     <= 1'b0;
      sign_q       <= 1'b0;
      data_iv_q    <= 1'b0;
      data_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      left_q       <= left_d;
      flush_left_q <= flush_left_d;
      rvalid_q     <= rd_en_q;
      sign_q       <= sign_d;
      data_iv_q    <= data_iv_d;
      data_id_q    <= data_id_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign data_iv      = data_iv_q;
  assign data_id      = data_id_q;
  assign data_sign_en = sign_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_sa_data_feeder.sv
// Bench for sa_data_feeder: buffer model with 1-cycle read latency, randomized tiles and
// stalls, and a tile-level reference (row list, address list, timing rules).
module tb_sa_data_feeder;

  localparam int W  = 8;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [AW-1:0]          base_addr;
  logic [CW-1:0]          num_rows;
  logic [3:0]             flush_rows;
  logic                   sign_en;
  logic                   stall;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [W*DW-1:0]        rd_data;
  logic                   data_iv;
  logic [W-1:0][DW-1:0]   data_id;
  logic                   data_sign_en;
  logic                   busy;
  logic                   done;

  int vectors = 0;
  int errors  = 0;

  logic [W*DW-1:0] mem [1 << AW];

  logic [W*DW-1:0] beats[$];
  int              beat_cyc[$];
  logic [AW-1:0]   addrs[$];
  logic [W*DW-1:0] exp_beats[$];
  logic [AW-1:0]   exp_addrs[$];
  int              done_cyc, done_cnt, stall_viol, busy_gap, sign_bad;
  logic            busy_after;
  bit              timed_out;

  sa_data_feeder #(
    .WIDTH      (W),
    .DATA_WIDTH (DW),
    .ADDR_W     (AW),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_rows     (num_rows),
    .flush_rows   (flush_rows),
    .sign_en      (sign_en),
    .stall        (stall),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .data_iv      (data_iv),
    .data_id      (data_id),
    .data_sign_en (data_sign_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Activation buffer: data valid the cycle after the strobe; ignores reset on purpose.
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= mem[rd_addr];
  end

  function automatic void fill_mem(input bit pattern);
    for (int k = 0; k < (1 << AW); k++) begin
      logic [7:0] kb;
      kb = k[7:0];
      mem[k] = pattern ? {8{kb}} : {$urandom, $urandom};
    end
  endfunction

  // Reference: n rows from consecutive (wrapping) addresses, then f zero rows.
  function automatic void build_exp(input logic [AW-1:0] b, input int n, input int f);
    exp_beats.delete();
    exp_addrs.delete();
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addrs.push_back(a);
      exp_beats.push_back(mem[a]);
    end
    for (int i = 0; i < f; i++) exp_beats.push_back('0);
  endfunction

  // Drives one tile (start in cycle 0) and records what the DUT does, cycle by cycle.
  task automatic run_tile(input logic [AW-1:0] b, input logic [CW-1:0] n,
                          input logic [3:0] f, input logic s, input int stall_pct,
                          input int restart_at, input int max_cyc);
    bit prev_stall;
    int cyc;
    prev_stall = 0;
    cyc = 0;
    beats.delete(); beat_cyc.delete(); addrs.delete();
    done_cyc = -1; done_cnt = 0; stall_viol = 0; busy_gap = 0; sign_bad = 0;
    busy_after = 1'b1; timed_out = 0;
    base_addr = b; num_rows = n; flush_rows = f; sign_en = s; stall = 1'b0; start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (data_iv === 1'b1) begin
        beats.push_back(data_id);
        beat_cyc.push_back(cyc);
        if (prev_stall) stall_viol++;
      end
      if (rd_en === 1'b1) addrs.push_back(rd_addr);
      if (data_sign_en !== s) sign_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 || done_cyc == cyc) begin
        if (busy !== 1'b1) busy_gap++;
      end else if (cyc == done_cyc + 1) begin
        busy_after = busy;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      // Tile parameters must only matter at the accepted start.
      base_addr = AW'($urandom);
      num_rows = CW'($urandom);
      flush_rows = 4'($urandom);
      sign_en = 1'($urandom);
      start = (cyc == restart_at);
      if (start) sign_en = ~s;
      stall = ($urandom_range(99) < stall_pct);
      prev_stall = stall;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; num_rows = '0;
    flush_rows = '0; sign_en = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rd_en, rd_addr, data_iv, data_id, data_sign_en, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {rd_en, rd_addr, data_iv, data_id, data_sign_en, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({data_iv, busy, done, rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0000", {data_iv, busy, done, rd_en});
    end
  endtask

  task automatic test_basic;
    fill_mem(1'b1);
    build_exp(10'h010, 4, 0);
    run_tile(10'h010, 8'd4, 4'd0, 1'b0, 0, -1, 60);
    vectors++;
    if (beats.size() != 4 || timed_out) begin
      errors++;
      $display("FAIL basic_beat_count got %0d want 4 (timeout %0d)", beats.size(), timed_out);
    end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      vectors++;
      if (beats[i] !== exp_beats[i] || beat_cyc[i] != 3 + i) begin
        errors++;
        $display("FAIL basic_beat%0d got %h@%0d want %h@%0d", i, beats[i], beat_cyc[i],
                 exp_beats[i], 3 + i);
      end
    end
    vectors++;
    if (done_cyc != 7 || done_cnt != 1 || busy_gap != 0 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got cyc %0d cnt %0d gap %0d after %b want 7 1 0 0",
               done_cyc, done_cnt, busy_gap, busy_after);
    end
    vectors++;
    if (addrs != exp_addrs) begin
      errors++;
      $display("FAIL basic_addrs got %p want %p", addrs, exp_addrs);
    end
  endtask

  task automatic test_flush;
    logic [AW-1:0] b;
    fill_mem(1'b0);
    b = AW'($urandom);
    build_exp(b, 2, 7);
    run_tile(b, 8'd2, 4'd7, 1'b0, 0, -1, 80);
    vectors++;
    if (beats != exp_beats || timed_out) begin
      errors++;
      $display("FAIL flush_rows got %0d beats want %0d (timeout %0d)", beats.size(),
               exp_beats.size(), timed_out);
    end
    for (int i = 0; i < beat_cyc.size(); i++) begin
      vectors++;
      if (beat_cyc[i] != 3 + i) begin
        errors++;
        $display("FAIL flush_cycle%0d got %0d want %0d", i, beat_cyc[i], 3 + i);
      end
    end
    vectors++;
    if (beat_cyc.size() == 0 || done_cyc != beat_cyc[$] + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL flush_done got %0d want last beat + 1", done_cyc);
    end
  endtask

  task automatic test_stall_storm;
    for (int it = 0; it < 4; it++) begin
      logic [AW-1:0] b;
      int f;
      fill_mem(1'b0);
      b = AW'($urandom);
      f = (it == 0) ? 0 : $urandom_range(0, 15);
      build_exp(b, 16, f);
      run_tile(b, 8'd16, 4'(f), 1'(it), 40, -1, 400);
      vectors++;
      if (beats != exp_beats || addrs != exp_addrs || timed_out) begin
        errors++;
        $display("FAIL storm%0d_rows got %0d beats %0d reads want %0d %0d (timeout %0d)",
                 it, beats.size(), addrs.size(), exp_beats.size(), exp_addrs.size(),
                 timed_out);
      end
      vectors++;
      if (stall_viol != 0) begin
        errors++;
        $display("FAIL storm%0d_stall got %0d beats after stall want 0", it, stall_viol);
      end
      vectors++;
      if (beat_cyc.size() == 0 || done_cyc != beat_cyc[$] + 1 || busy_gap != 0 ||
          sign_bad != 0) begin
        errors++;
        $display("FAIL storm%0d_done got cyc %0d gap %0d sign %0d want last+1 0 0",
                 it, done_cyc, busy_gap, sign_bad);
      end
    end
  endtask

  task automatic test_boundaries;
    fill_mem(1'b0);
    build_exp(10'h3FE, 4, 0);
    run_tile(10'h3FE, 8'd4, 4'd0, 1'b0, 0, -1, 60);
    vectors++;
    if (addrs != exp_addrs || beats != exp_beats) begin
      errors++;
      $display("FAIL wrap_addrs got %p want %p", addrs, exp_addrs);
    end
    run_tile(10'h155, 8'd0, 4'd0, 1'b0, 0, -1, 20);
    vectors++;
    if (done_cyc != 1 || beats.size() != 0 || busy_gap != 0 || addrs.size() != 0) begin
      errors++;
      $display("FAIL zero_tile got done %0d beats %0d reads %0d gap %0d want 1 0 0 0",
               done_cyc, beats.size(), addrs.size(), busy_gap);
    end
  endtask

  task automatic test_control;
    logic [AW-1:0] b;
    fill_mem(1'b0);
    b = AW'($urandom);
    build_exp(b, 6, 2);
    run_tile(b, 8'd6, 4'd2, 1'b1, 20, 3, 200);
    vectors++;
    if (beats != exp_beats || addrs != exp_addrs || done_cnt != 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored got %0d beats done %0d busy_after %b want %0d 1 0",
               beats.size(), done_cnt, busy_after, exp_beats.size());
    end
    vectors++;
    if (sign_bad != 0) begin
      errors++;
      $display("FAIL sign_en_held got %0d bad cycles want 0", sign_bad);
    end
  endtask

  task automatic test_reset_mid_tile;
    int cnt, cyc, bad;
    logic [AW-1:0] b;
    fill_mem(1'b0);
    base_addr = AW'($urandom); num_rows = 8'd20; flush_rows = 4'd3; sign_en = 1'b1;
    start = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (data_iv === 1'b1) cnt++;
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({rd_en, rd_addr, data_iv, data_id, data_sign_en, busy, done} !== '0 || cnt != 3) begin
      errors++;
      $display("FAIL midreset_outputs got %h (beats %0d) want 0 (3)",
               {rd_en, rd_addr, data_iv, data_id, data_sign_en, busy, done}, cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || data_iv !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles want 0", bad);
    end
    b = AW'($urandom);
    build_exp(b, 5, 1);
    run_tile(b, 8'd5, 4'd1, 1'b0, 0, -1, 60);
    vectors++;
    if (beats != exp_beats || addrs != exp_addrs || done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_next_tile got %0d beats %0d reads want %0d %0d",
               beats.size(), addrs.size(), exp_beats.size(), exp_addrs.size());
    end
  endtask

  task automatic test_random_tiles;
    for (int it = 0; it < 8; it++) begin
      logic [AW-1:0] b;
      int n, f;
      b = AW'($urandom);
      n = $urandom_range(0, 12);
      f = $urandom_range(0, 15);
      build_exp(b, n, f);
      run_tile(b, CW'(n), 4'(f), 1'($urandom), $urandom_range(0, 50), -1, 300);
      vectors++;
      if (beats != exp_beats || addrs != exp_addrs || timed_out || stall_viol != 0) begin
        errors++;
        $display("FAIL rand%0d_stream got %0d beats %0d reads viol %0d want %0d %0d 0", it,
                 beats.size(), addrs.size(), stall_viol, exp_beats.size(), exp_addrs.size());
      end
      vectors++;
      if (done_cyc != ((beat_cyc.size() == 0) ? 1 : beat_cyc[$] + 1) || busy_gap != 0 ||
          busy_after !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_done got cyc %0d gap %0d after %b", it, done_cyc, busy_gap,
                 busy_after);
      end
    end
  endtask

  initial begin
    rd_data = '0;
    test_reset();
    test_basic();
    test_flush();
    test_stall_storm();
    test_boundaries();
    test_control();
    test_reset_mid_tile();
    test_random_tiles();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sa_data_feeder.md
# sa_data_feeder

Streaming source for the systolic array data input. On `start`, it reads a tile of `num_rows` ifmap rows from the on-chip activation buffer through a 1-cycle-latency read port. It emits one row per cycle on `data_iv`/`data_id`/`data_sign_en`, then emits `flush_rows` zero rows to drain the array. It sits between the activation buffer and the systolic array top and is the transmitter side of the array's `data_iv`/`data_id` input. It honours a downstream `stall` without losing or duplicating rows.

## Interface
- `WIDTH`, 8: lanes per row. Equals the array width.
- `DATA_WIDTH`, 8: bits per lane.
- `ADDR_W`, 10: activation buffer address width.
- `CNT_W`, 8: width of the row counter.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request. Ignored while `busy`.
- `base_addr` in ADDR_W: address of the first row. Sampled with `start`.
- `num_rows` in CNT_W: rows to stream. Sampled with `start`. 0 is legal.
- `flush_rows` in 4: zero rows appended after the data rows. Sampled with `start`.
- `sign_en` in 1: signedness of the tile. Sampled with `start`.
- `stall` in 1: downstream hold. While high, no beat is emitted.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: buffer read address.
- `rd_data` in WIDTH*DATA_WIDTH: read data, valid exactly 1 cycle after `rd_en`.
- `data_iv` out 1: row valid toward the array.
- `data_id` out [WIDTH-1:0][DATA_WIDTH-1:0]: row data.
- `data_sign_en` out 1: latched `sign_en`, constant for the whole tile.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle pulse at tile completion.

## Operation
- FSM states: IDLE, FETCH, FLUSH, DONE.
- IDLE: on `start`, latch the parameters and go to the next state.
  - Next state is FETCH if `num_rows`≠0.
  - Else FLUSH if `flush_rows`≠0.
  - Else DONE.
- FETCH:
  - Issue a read when `fifo_count + inflight < 2`. `rd_addr` starts at `base_addr` and increments by 1 per issued read, wrapping modulo 2^ADDR_W.
  - Returned data goes to the output register by bypass if the output is free this cycle. Otherwise it goes into the 2-entry FIFO.
  - When all `num_rows` reads have been issued, wait for FIFO empty and no read in flight.
  - Then go to FLUSH, or to DONE if `flush_rows`=0.
- FLUSH: emit `flush_rows` beats of all-zero `data_id` with `data_iv`=1, subject to `stall`. Then go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Output register, evaluated each edge:
  - If `stall`=0 and a row is available (FIFO head, or bypass data, or a flush beat): `data_iv`←1 and `data_id`←row.
  - Otherwise `data_iv`←0 and `data_id` holds its last value.
- `stall` never drops, duplicates, or reorders rows. Reads in flight during a stall land in the FIFO. Credit rule: at most 2 rows are buffered or in flight.
- `start` while `busy`: ignored, no parameter change.
- `rst` mid-tile:
  - All outputs go to their reset values immediately.
  - The tile is abandoned.
  - A late `rd_data` is discarded.
- Reset values:
  - `rd_en`=0, `rd_addr`=0, `data_iv`=0, `data_id`=0, `data_sign_en`=0, `busy`=0, `done`=0.
  - FSM in IDLE, FIFO empty.

## Timing
- `start` high in cycle 0, no stall:
  - `busy` and `rd_en` are high from cycle 1, with `rd_addr`=`base_addr`.
  - The first `data_iv` beat appears in cycle 3.
  - Throughput is 1 row/cycle.
- Last beat of the tile (data or flush) in cycle N: `done`=1 in cycle N+1.
- `busy` is high from cycle 1 through the `done` cycle, inclusive.
- `stall` high in cycle c: `data_iv`=0 in cycle c+1. Stall-to-resume latency is 1 cycle.
- `data_sign_en` changes only in the cycle after an accepted `start`.
- Zero-length tile (`num_rows`=0, `flush_rows`=0): `busy`=1 and `done`=1 in cycle 1. No beat is emitted.

## Structure
- Shared package `sa_pkg`: `feed_state_t` enum (IDLE/FETCH/FLUSH/DONE), and a row typedef `[WIDTH-1:0][DATA_WIDTH-1:0]`.
- Sub-module `sa_feed_fifo`: 2-entry FIFO with a count output, no overflow possible by the credit rule. The FSM, address counter, row counters and output register stay in the top.

## Test plan
- Basic stream:
  - Stimulus: `base_addr`=0x10, `num_rows`=4, `flush_rows`=0, buffer row k = {8{k}}, no stall.
  - Required: beats {8{0x10}}..{8{0x13}} in cycles 3-6, and `done` in cycle 7.
- Flush:
  - Stimulus: `num_rows`=2, `flush_rows`=7.
  - Required: 2 data beats followed by 7 all-zero beats with `data_iv`=1, then `done`.
- Stall storm:
  - Stimulus: `num_rows`=16, random 40% `stall`.
  - Required: exactly 16 beats, in address order, no gaps in content, and no beat in any cycle following a stall-high cycle.
- Boundaries:
  - `base_addr`=0x3FE with `num_rows`=4 → `rd_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
  - `num_rows`=0 with `flush_rows`=0 → `done` in cycle 1 and no beats.
- Control:
  - `start` pulsed again during a tile → ignored, and the original parameters are completed.
  - `sign_en`=1 → `data_sign_en`=1 through the whole tile.
- Reset mid-tile: `rst` after 3 beats → outputs are 0 at once, no `done`, and a subsequent tile streams correctly from its own `base_addr`.
